// File: rtl/mux8_1.sv
// mux8_1 -- 8-to-1 lane selector with registered copy.
//
// Picks lane s of eight packed DATA_W-bit lanes onto a combinational output,
// and also registers the selected lane, the select, and a select-change pulse
// for downstream synchronous logic.
//
// Ports:
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous reset, active-high
//   s          in   3         lane select 0..7
//   in         in   8*DATA_W  packed lanes, lane k = in[k*DATA_W +: DATA_W]
//   out        out  DATA_W    combinational selected lane
//   out_q      out  DATA_W    registered selected lane (1-cycle lag)
//   s_q        out  3         registered select (1-cycle lag)
//   sel_change out  1         one-cycle pulse when registered s changes
//   sel_oh     out  8         combinational one-hot of s
//                             (only with MUX8_1_SEL_ONEHOT_EN defined)
//
// Optional feature macro: MUX8_1_SEL_ONEHOT_EN
module mux8_1 #(
    parameter int DATA_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          s,
    input  logic [8*DATA_W-1:0] in,
    output logic [DATA_W-1:0]   out,
    output logic [DATA_W-1:0]   out_q,
    output logic [2:0]          s_q,
    output logic                sel_change
`ifdef MUX8_1_SEL_ONEHOT_EN
    ,
    output logic [7:0]          sel_oh
`endif
);

    // Flat bus viewed as a packed lane array; lane 0 sits at the LSBs.
    logic [7:0][DATA_W-1:0] lanes;

    assign lanes = in;

    // Unresolved select (X/Z) falls to the default and yields zeros.
    always_comb begin
        out = '0;
        case (s)
            3'd0:    out = lanes[0];
            3'd1:    out = lanes[1];
            3'd2:    out = lanes[2];
            3'd3:    out = lanes[3];
            3'd4:    out = lanes[4];
            3'd5:    out = lanes[5];
            3'd6:    out = lanes[6];
            3'd7:    out = lanes[7];
            default: out = '0;
        endcase
    end

    // sel_change compares the incoming select against the already-registered
    // one, so it pulses in the same cycle s_q takes the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            s_q        <= 3'd0;
            sel_change <= 1'b0;
        end else begin
            out_q      <= out;
            s_q        <= s;
            sel_change <= (s != s_q);
        end
    end

`ifdef MUX8_1_SEL_ONEHOT_EN
    always_comb begin
        sel_oh = 8'h00;
        case (s)
            3'd0:    sel_oh = 8'b0000_0001;
            3'd1:    sel_oh = 8'b0000_0010;
            3'd2:    sel_oh = 8'b0000_0100;
            3'd3:    sel_oh = 8'b0000_1000;
            3'd4:    sel_oh = 8'b0001_0000;
            3'd5:    sel_oh = 8'b0010_0000;
            3'd6:    sel_oh = 8'b0100_0000;
            3'd7:    sel_oh = 8'b1000_0000;
            default: sel_oh = 8'h00;
        endcase
    end
`endif

endmodule

// File: tb/tb_mux8_1.sv
// tb_mux8_1 -- directed self-checking bench for mux8_1.
// Two instances share clk/rst/s: DATA_W=1 (u1) and DATA_W=4 (u4).
module tb_mux8_1;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  s = 3'd0;
    logic [7:0]  in1 = 8'b1010_1010;
    logic [31:0] in4 = 32'h7654_3210;

    logic        out1, out_q1, sc1;
    logic [2:0]  s_q1;
    logic [3:0]  out4, out_q4;
    logic [2:0]  s_q4;
    logic        sc4;
`ifdef MUX8_1_SEL_ONEHOT_EN
    logic [7:0]  oh1, oh4;
`endif

    int nchk = 0;
    int nfail = 0;

    mux8_1 #(.DATA_W(1)) u1 (
        .clk(clk), .rst(rst), .s(s), .in(in1),
        .out(out1), .out_q(out_q1), .s_q(s_q1), .sel_change(sc1)
`ifdef MUX8_1_SEL_ONEHOT_EN
        , .sel_oh(oh1)
`endif
    );

    mux8_1 #(.DATA_W(4)) u4 (
        .clk(clk), .rst(rst), .s(s), .in(in4),
        .out(out4), .out_q(out_q4), .s_q(s_q4), .sel_change(sc4)
`ifdef MUX8_1_SEL_ONEHOT_EN
        , .sel_oh(oh4)
`endif
    );

    // Clock stays parked low until the registered tests start.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_exp;

    initial begin
        // Combinational sweep, no clock running.
        sweep_exp = 8'b1010_1010;
        for (int k = 0; k < 8; k++) begin
            s = 3'(k);
            #10;
            chk($sformatf("sweep1_s%0d", k), 32'(out1), 32'(sweep_exp[k]));
            chk($sformatf("sweep4_s%0d", k), 32'(out4), k);
        end

        // Reset held for two cycles.
        rst = 1'b1; s = 3'd5; in1 = 8'hFF;
        clk_en = 1'b1;
        tick(); tick();
        chk("rst_out_q", 32'(out_q1), 0);
        chk("rst_s_q", 32'(s_q1), 0);
        chk("rst_selc", 32'(sc1), 0);
        chk("rst_out", 32'(out1), 1);

        // Release with s=5 held.
        rst = 1'b0;
        tick();
        chk("rel1_out_q", 32'(out_q1), 1);
        chk("rel1_s_q", 32'(s_q1), 5);
        chk("rel1_selc", 32'(sc1), 1);
        tick();
        chk("rel2_selc", 32'(sc1), 0);
        chk("rel2_s_q", 32'(s_q1), 5);

        // 5 -> 3, then 3 -> 4 with only lane 4 set.
        s = 3'd3; in1 = 8'b0001_0000;
        #1 chk("s3_out", 32'(out1), 0);
        tick();
        chk("s3_selc", 32'(sc1), 1);
        chk("s3_s_q", 32'(s_q1), 3);
        chk("s3_out_q", 32'(out_q1), 0);
        tick();
        chk("s3_hold_selc", 32'(sc1), 0);
        s = 3'd4;
        #1 chk("s4_out_now", 32'(out1), 1);
        chk("s4_out_q_old", 32'(out_q1), 0);
        tick();
        chk("s4_out_q", 32'(out_q1), 1);
        chk("s4_selc", 32'(sc1), 1);
        chk("s4_s_q", 32'(s_q1), 4);
        tick();
        chk("s4_hold_selc", 32'(sc1), 0);

        // Wide lanes.
        s = 3'd6;
        #1 chk("w4_out", 32'(out4), 6);
        tick();
        chk("w4_out_q", 32'(out_q4), 6);
        chk("w4_s_q", 32'(s_q4), 6);

        // Reset mid-operation.
        s = 3'd1; in1 = 8'h02;
        tick();
        chk("mid_pre_selc", 32'(sc1), 1);
        chk("mid_pre_out_q", 32'(out_q1), 1);
        rst = 1'b1; s = 3'd2; in1 = 8'h04;
        #1 chk("mid_out", 32'(out1), 1);
        tick();
        chk("mid_out_q", 32'(out_q1), 0);
        chk("mid_s_q", 32'(s_q1), 0);
        chk("mid_selc", 32'(sc1), 0);
        chk("mid_out_live", 32'(out1), 1);

        // Release with s=0: no pulse on first cycle.
        rst = 1'b0; s = 3'd0;
        tick();
        chk("rel0_selc", 32'(sc1), 0);
        chk("rel0_out_q", 32'(out_q1), 0);

        // Simultaneous s and in change.
        s = 3'd7; in1 = 8'h80;
        #1 chk("simul_out", 32'(out1), 1);
        tick();
        chk("simul_out_q", 32'(out_q1), 1);
        chk("simul_selc", 32'(sc1), 1);

`ifdef MUX8_1_SEL_ONEHOT_EN
        s = 3'd2;
        #1 chk("oh_s2", 32'(oh1), 32'h04);
        s = 3'd7;
        #1 chk("oh_s7", 32'(oh4), 32'h80);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/mux8_1.md
Name: mux8_1

Overview:
- 8-to-1 selector: picks one of eight input lanes using a 3-bit select and drives it on a combinational output.
- Also provides a registered copy of the selected lane, the registered select, and a select-change pulse, for downstream synchronous logic.
- General-purpose datapath leaf cell; defaults to 1-bit lanes packed into an 8-bit input bus.

Parameters:
- DATA_W, 1, width of each input lane and of out/out_q; must be >= 1.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- s  input  3  lane select, 0..7
- in  input  8*DATA_W  packed lanes; lane k = in[k*DATA_W +: DATA_W]
- out  output  DATA_W  combinational selected lane
- out_q  output  DATA_W  registered selected lane
- s_q  output  3  registered select
- sel_change  output  1  one-cycle pulse: registered s differed from previous registered s

Behaviour:
- Combinational path:
  - out = lane s of in, for every s in 0..7.
  - Zero latency; no dependence on clk or rst; valid with no clock toggling.
  - Any change on s or in propagates to out in the same delta/timestep.
  - Lane 0 is the LSB lane: DATA_W=1, in=8'b10101010, s=0 gives out=0; s=7 gives out=1.
  - Any s value not resolving to 0..7 (X/Z in simulation) drives out to all-zeros via the default branch; no latch inferred.
- Registered path, updated on rising clk:
  - rst=1: out_q=0, s_q=0, sel_change=0. Reset has priority over all other updates.
  - rst=0: out_q <= lane s of in (same value as out that cycle); s_q <= s; sel_change <= (s != s_q).
  - Latency: out_q and s_q lag inputs by exactly 1 cycle.
  - sel_change asserts for exactly one cycle per select change.
  - A select held constant gives sel_change=0 from the second cycle onward.
- First cycle after reset release: sel_change=1 if s != 0, else 0.
- Reset mid-operation: registered outputs clear on the same edge; out is unaffected and keeps following s/in.
- Simultaneous change of s and in: out and out_q reflect the new s applied to the new in.
- All registers are plain DFFs with synchronous reset. No gated clocks, no asynchronous paths.

Optional Feature:
- Macro: MUX8_1_SEL_ONEHOT_EN.
- Defined:
  - Adds output port sel_oh, width 8, combinational.
  - sel_oh = 1 << s for s in 0..7; all-zeros for unresolved s.
  - Exactly one bit set for any valid s.
  - Unaffected by clk and rst.
- Undefined: port sel_oh and its logic are absent; all other behaviour is identical.

Test Plan:
- DATA_W=1, in=8'b10101010, sweep s=0..7 at 10 ns steps, no clock -> out = 0,1,0,1,0,1,0,1 respectively.
- rst=1 for 2 cycles with s=5, in=8'hFF -> out_q=0, s_q=0, sel_change=0 while rst=1; out=1 throughout.
- Release rst, hold s=5, in=8'hFF -> cycle 1: out_q=1, s_q=5, sel_change=1; cycle 2: sel_change=0.
- s changes 3->4 on one edge with in=8'b00010000 -> out goes 0->1 immediately; out_q=1 and sel_change=1 after the next edge; sel_change=0 on the edge after.
- DATA_W=4, in=32'h76543210, s=6 -> out=4'h6, out_q=4'h6 after one edge.
- With MUX8_1_SEL_ONEHOT_EN defined, s=2 -> sel_oh=8'b00000100; s=7 -> 8'b10000000.
